// File: rtl/des_sbox_sched_if.sv
// Request/response bundle between two round-function sequencers and the shared
// DES S-box substitution engine.
interface des_sbox_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [48:1] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [48:1] req1_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [32:1] rsp_data;
    logic        rsp_id;
    logic        busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/des_sbox_sched.sv
// Shared DES S-box engine: round-robin accepts a 48-bit operand from one of two
// requesters, runs S1..S8 over 8/LANES cycles and returns the tagged 32-bit word.
module des_sbox_sched #(
    parameter int LANES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    des_sbox_sched_if.slave   sbox_if
);
    localparam int STEPS = 8 / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Entry [k][row*16+col] is S-box k+1; element 0 of each level sits at the MSB end.
    localparam logic [0:7][0:63][3:0] SBOX_TABLE = {
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6850926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };

    state_t          state_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [0:7][5:0] op_q;
    logic [0:7][3:0] res_q, res_d;
    logic            id_q;
    logic            last_grant_q;
    logic            rsp_valid_q;
    logic            grant_valid;
    logic            grant_id;
    logic [2:0]      lane_chunk [LANES];
    logic [3:0]      lane_nib   [LANES];

    // Outer index bits pick the row, inner four bits pick the column.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] idx);
        return SBOX_TABLE[box][{idx[5], idx[0], idx[4:1]}];
    endfunction

    always_comb begin
        grant_valid = sbox_if.req0_valid | sbox_if.req1_valid;
        if (sbox_if.req0_valid && sbox_if.req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = sbox_if.req1_valid;
        end
    end

    // Gated by rst_n so readies drop the moment reset asserts, not at release.
    assign sbox_if.req0_ready = rst_n && (state_q == IDLE) && grant_valid && !grant_id;
    assign sbox_if.req1_ready = rst_n && (state_q == IDLE) && grant_valid &&  grant_id;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_chunk[gi] = 3'(int'(cnt_q) * LANES + gi);
            assign lane_nib[gi]   = sbox_lookup(lane_chunk[gi], op_q[lane_chunk[gi]]);
        end
    endgenerate

    always_comb begin
        res_d = res_q;
        for (int l = 0; l < LANES; l++) begin
            res_d[lane_chunk[l]] = lane_nib[l];
        end
        cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            res_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        op_q         <= grant_id ? sbox_if.req1_data : sbox_if.req0_data;
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        cnt_q        <= '0;
                        res_q        <= '0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST_STEP) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (sbox_if.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sbox_if.rsp_valid = rsp_valid_q;
    assign sbox_if.rsp_data  = res_q;
    assign sbox_if.rsp_id    = id_q;
    assign sbox_if.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_des_sbox_sched.sv
// Bench for des_sbox_sched: LANES=1 instance for protocol scenarios plus
// LANES=2/4/8 instances for latency and result checks against a table model.
module tb_des_sbox_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    des_sbox_sched_if if_l1 ();
    des_sbox_sched_if if_l2 ();
    des_sbox_sched_if if_l4 ();
    des_sbox_sched_if if_l8 ();

    des_sbox_sched #(.LANES(1)) u_dut_l1 (.clk(clk), .rst_n(rst_n), .sbox_if(if_l1));
    des_sbox_sched #(.LANES(2)) u_dut_l2 (.clk(clk), .rst_n(rst_n), .sbox_if(if_l2));
    des_sbox_sched #(.LANES(4)) u_dut_l4 (.clk(clk), .rst_n(rst_n), .sbox_if(if_l4));
    des_sbox_sched #(.LANES(8)) u_dut_l8 (.clk(clk), .rst_n(rst_n), .sbox_if(if_l8));

    int n_checks = 0;
    int n_fail   = 0;
    bit model_last_grant = 1'b1;

    // Standard DES S-boxes, row-major (row*16 + column).
    int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [31:0] model_sbox(input logic [47:0] d);
        logic [31:0] r;
        int six, row, col;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            six = int'((d >> (42 - 6 * k)) & 48'h3F);
            row = ((six >> 5) & 1) * 2 + (six & 1);
            col = (six >> 1) & 15;
            r = r | (32'(SB[k][row * 16 + col]) << (28 - 4 * k));
        end
        return r;
    endfunction

    function automatic logic [47:0] rand48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_l1.req0_valid = 0; if_l1.req1_valid = 0; if_l1.req0_data = '0; if_l1.req1_data = '0;
        if_l2.req0_valid = 0; if_l2.req1_valid = 0; if_l2.req0_data = '0; if_l2.req1_data = '0;
        if_l4.req0_valid = 0; if_l4.req1_valid = 0; if_l4.req0_data = '0; if_l4.req1_data = '0;
        if_l8.req0_valid = 0; if_l8.req1_valid = 0; if_l8.req0_data = '0; if_l8.req1_data = '0;
        if_l1.rsp_ready = 1; if_l2.rsp_ready = 1; if_l4.rsp_ready = 1; if_l8.rsp_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_last_grant = 1'b1;
        tick();
    endtask

    // Runs one transaction on the LANES=1 instance; returns observations only.
    task automatic drive_txn1(input bit rid, input logic [47:0] data, output int lat,
                              output logic [31:0] rdata, output logic rid_seen, output bit timed_out);
        int w;
        lat = 0; rdata = '0; rid_seen = 1'b0; timed_out = 1'b0; w = 0;
        if (rid) begin if_l1.req1_valid = 1; if_l1.req1_data = data; end
        else     begin if_l1.req0_valid = 1; if_l1.req0_data = data; end
        #1;
        while (!(rid ? if_l1.req1_ready : if_l1.req0_ready)) begin
            tick(); #1; w++;
            if (w > 50) begin timed_out = 1'b1; if_l1.req0_valid = 0; if_l1.req1_valid = 0; return; end
        end
        @(posedge clk);
        #1;
        if_l1.req0_valid = 0; if_l1.req1_valid = 0;
        model_last_grant = rid;
        while (lat < 40) begin
            tick(); lat++;
            if (if_l1.rsp_valid) break;
        end
        if (!if_l1.rsp_valid) timed_out = 1'b1;
        rdata = if_l1.rsp_data; rid_seen = if_l1.rsp_id;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        tick();
        if_l1.req0_valid = 1; if_l1.req1_valid = 1;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (if_l1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", if_l1.rsp_valid); end
        n_checks++; if (if_l1.rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 00000000", if_l1.rsp_data); end
        n_checks++; if (if_l1.rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %b expected 0", if_l1.rsp_id); end
        n_checks++; if (if_l1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", if_l1.busy); end
        n_checks++; if (if_l1.req0_ready !== 1'b0 || if_l1.req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_readies: got %b%b expected 00", if_l1.req0_ready, if_l1.req1_ready); end
        do_reset();
        $display("test_reset: done");
    endtask

    task automatic test_known_vectors();
        logic [47:0] vd [3];
        logic [31:0] ve [3];
        bit vid [3];
        int lat; logic [31:0] rd; logic ri; bit to;
        vd = '{48'h0, 48'hFFFFFFFFFFFF, 48'h040000000000};
        ve = '{32'hEFA72C4D, 32'hD9CE3DCB, 32'h0FA72C4D};
        vid = '{1'b0, 1'b1, 1'b0};
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_txn1(vid[i], vd[i], lat, rd, ri, to);
            n_checks++; if (to) begin n_fail++; $display("FAIL vec%0d_timeout: got timeout expected response", i); end
            n_checks++; if (rd !== ve[i]) begin n_fail++; $display("FAIL vec%0d_data: got %h expected %h", i, rd, ve[i]); end
            n_checks++; if (ri !== vid[i]) begin n_fail++; $display("FAIL vec%0d_id: got %b expected %b", i, ri, vid[i]); end
            n_checks++; if (lat != 8) begin n_fail++; $display("FAIL vec%0d_latency: got %0d expected 8", i, lat); end
            $display("known vector %0d: id=%0d data=%h rsp=%h lat=%0d", i, vid[i], vd[i], rd, lat);
        end
    endtask

    task automatic test_lanes();
        logic [47:0] d;
        int lat [4];
        logic [31:0] dat [4];
        tick();
        for (int v = 0; v < 3; v++) begin
            d = (v == 0) ? 48'h0 : (v == 1) ? 48'hFFFFFFFFFFFF : rand48();
            lat = '{0, 0, 0, 0};
            dat = '{32'h0, 32'h0, 32'h0, 32'h0};
            if_l1.req0_data = d; if_l2.req0_data = d; if_l4.req0_data = d; if_l8.req0_data = d;
            if_l1.req0_valid = 1; if_l2.req0_valid = 1; if_l4.req0_valid = 1; if_l8.req0_valid = 1;
            @(posedge clk); #1;
            if_l1.req0_valid = 0; if_l2.req0_valid = 0; if_l4.req0_valid = 0; if_l8.req0_valid = 0;
            model_last_grant = 1'b0;
            for (int e = 1; e <= 12; e++) begin
                tick();
                if (lat[0] == 0 && if_l1.rsp_valid) begin lat[0] = e; dat[0] = if_l1.rsp_data; end
                if (lat[1] == 0 && if_l2.rsp_valid) begin lat[1] = e; dat[1] = if_l2.rsp_data; end
                if (lat[2] == 0 && if_l4.rsp_valid) begin lat[2] = e; dat[2] = if_l4.rsp_data; end
                if (lat[3] == 0 && if_l8.rsp_valid) begin lat[3] = e; dat[3] = if_l8.rsp_data; end
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (lat[i] != 8 / (1 << i)) begin n_fail++;
                    $display("FAIL lanes%0d_latency: got %0d expected %0d", 1 << i, lat[i], 8 / (1 << i)); end
                n_checks++; if (dat[i] !== model_sbox(d)) begin n_fail++;
                    $display("FAIL lanes%0d_data: got %h expected %h", 1 << i, dat[i], model_sbox(d)); end
            end
            $display("lanes vector %0d: data=%h latencies=%0d/%0d/%0d/%0d", v, d, lat[0], lat[1], lat[2], lat[3]);
        end
    endtask

    task automatic test_random();
        logic [47:0] d; bit rid;
        int lat; logic [31:0] rd; logic ri; bit to;
        tick();
        for (int i = 0; i < 8; i++) begin
            d = rand48(); rid = 1'($urandom);
            drive_txn1(rid, d, lat, rd, ri, to);
            n_checks++; if (to || rd !== model_sbox(d)) begin n_fail++;
                $display("FAIL rand%0d_data: got %h expected %h", i, rd, model_sbox(d)); end
            n_checks++; if (ri !== rid) begin n_fail++; $display("FAIL rand%0d_id: got %b expected %b", i, ri, rid); end
            n_checks++; if (lat != 8) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected 8", i, lat); end
            $display("random txn %0d: id=%0d data=%h rsp=%h", i, rid, d, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] q_data [$];
        bit q_id [$];
        int acc, guard;
        bit bad_ready, took, exp, eid;
        logic [47:0] ed;
        do_reset();
        acc = 0; guard = 0; bad_ready = 0; exp = 0;
        if_l1.req0_data = rand48(); if_l1.req1_data = rand48();
        if_l1.req0_valid = 1; if_l1.req1_valid = 1;
        #1;
        while ((acc < 4 || q_data.size() != 0) && guard < 200) begin
            guard++; took = 0;
            if (if_l1.rsp_valid) begin
                n_checks++;
                if (q_data.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected_rsp: got id %b expected no response", if_l1.rsp_id);
                end else begin
                    ed = q_data.pop_front(); eid = q_id.pop_front();
                    if (if_l1.rsp_data !== model_sbox(ed) || if_l1.rsp_id !== eid) begin
                        n_fail++; $display("FAIL b2b_rsp: got %h/%b expected %h/%b",
                                           if_l1.rsp_data, if_l1.rsp_id, model_sbox(ed), eid);
                    end
                    $display("b2b response: id=%0d data=%h", if_l1.rsp_id, if_l1.rsp_data);
                end
            end
            if (if_l1.busy && (if_l1.req0_ready || if_l1.req1_ready)) bad_ready = 1;
            if (!if_l1.busy && acc < 4) begin
                exp = !model_last_grant;
                n_checks++;
                if (if_l1.req0_ready !== !exp || if_l1.req1_ready !== exp) begin
                    n_fail++; $display("FAIL b2b_grant%0d: got ready %b%b expected grant %0d",
                                       acc, if_l1.req0_ready, if_l1.req1_ready, exp);
                end
                q_data.push_back(exp ? if_l1.req1_data : if_l1.req0_data);
                q_id.push_back(exp);
                model_last_grant = exp; acc++; took = 1;
            end
            @(posedge clk); #1;
            if (took) begin
                if (exp) if_l1.req1_data = rand48(); else if_l1.req0_data = rand48();
                if (acc == 4) begin if_l1.req0_valid = 0; if_l1.req1_valid = 0; end
            end
            #1;
        end
        n_checks++; if (acc != 4 || q_data.size() != 0) begin n_fail++;
            $display("FAIL b2b_progress: got %0d accepts %0d pending expected 4 accepts 0 pending", acc, q_data.size()); end
        n_checks++; if (bad_ready) begin n_fail++; $display("FAIL b2b_ready_while_busy: got 1 expected 0"); end
    endtask

    task automatic test_backpressure();
        logic [47:0] d0, d1;
        logic [31:0] held; logic held_id;
        bit bad_valid, bad_data, bad_ready;
        int w;
        tick();
        d0 = rand48(); d1 = rand48();
        if_l1.rsp_ready = 0;
        if_l1.req0_data = d0; if_l1.req0_valid = 1;
        #1;
        n_checks++; if (if_l1.req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b expected 1", if_l1.req0_ready); end
        @(posedge clk); #1;
        if_l1.req0_valid = 0; model_last_grant = 0;
        if_l1.req1_data = d1; if_l1.req1_valid = 1;
        w = 0;
        while (!if_l1.rsp_valid && w < 20) begin tick(); w++; end
        held = if_l1.rsp_data; held_id = if_l1.rsp_id;
        n_checks++; if (held !== model_sbox(d0) || held_id !== 1'b0) begin n_fail++;
            $display("FAIL bp_result: got %h/%b expected %h/0", held, held_id, model_sbox(d0)); end
        bad_valid = 0; bad_data = 0; bad_ready = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (if_l1.rsp_valid !== 1'b1) bad_valid = 1;
            if (if_l1.rsp_data !== held || if_l1.rsp_id !== held_id) bad_data = 1;
            if (if_l1.req0_ready !== 1'b0 || if_l1.req1_ready !== 1'b0) bad_ready = 1;
        end
        n_checks++; if (bad_valid) begin n_fail++; $display("FAIL bp_valid_held: got drop expected held high"); end
        n_checks++; if (bad_data) begin n_fail++; $display("FAIL bp_data_stable: got change expected %h/%b", held, held_id); end
        n_checks++; if (bad_ready) begin n_fail++; $display("FAIL bp_ready_low: got ready high expected 0"); end
        if_l1.rsp_ready = 1;
        tick();
        n_checks++; if (if_l1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", if_l1.rsp_valid); end
        n_checks++; if (if_l1.req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", if_l1.req1_ready); end
        tick();
        if_l1.req1_valid = 0; model_last_grant = 1;
        n_checks++; if (if_l1.busy !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept: got busy %b expected 1", if_l1.busy); end
        w = 0;
        while (!if_l1.rsp_valid && w < 20) begin tick(); w++; end
        n_checks++; if (if_l1.rsp_data !== model_sbox(d1) || if_l1.rsp_id !== 1'b1) begin n_fail++;
            $display("FAIL bp_next_result: got %h/%b expected %h/1", if_l1.rsp_data, if_l1.rsp_id, model_sbox(d1)); end
        $display("backpressure: held=%h next=%h", held, if_l1.rsp_data);
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [47:0] d;
        bit seen;
        int w;
        tick();
        d = rand48();
        if_l1.req0_data = d; if_l1.req0_valid = 1;
        @(posedge clk); #1;
        if_l1.req0_valid = 0; model_last_grant = 0;
        repeat (3) @(posedge clk);
        #2;
        if_l1.req0_valid = 1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (if_l1.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", if_l1.busy); end
        n_checks++; if (if_l1.rsp_valid !== 1'b0 || if_l1.rsp_data !== 32'h0 || if_l1.rsp_id !== 1'b0) begin n_fail++;
            $display("FAIL midrst_rsp: got %b/%h/%b expected 0/00000000/0", if_l1.rsp_valid, if_l1.rsp_data, if_l1.rsp_id); end
        n_checks++; if (if_l1.req0_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", if_l1.req0_ready); end
        do_reset();
        seen = 0;
        for (int c = 0; c < 15; c++) begin tick(); if (if_l1.rsp_valid) seen = 1; end
        n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_no_rsp: got response expected none"); end
        if_l1.req0_data = d; if_l1.req1_data = rand48();
        if_l1.req0_valid = 1; if_l1.req1_valid = 1;
        #1;
        n_checks++; if (if_l1.req0_ready !== 1'b1 || if_l1.req1_ready !== 1'b0) begin n_fail++;
            $display("FAIL midrst_first_grant: got ready %b%b expected 10", if_l1.req0_ready, if_l1.req1_ready); end
        @(posedge clk); #1;
        if_l1.req0_valid = 0; if_l1.req1_valid = 0; model_last_grant = 0;
        w = 0;
        while (!if_l1.rsp_valid && w < 20) begin tick(); w++; end
        n_checks++; if (if_l1.rsp_data !== model_sbox(d) || if_l1.rsp_id !== 1'b0) begin n_fail++;
            $display("FAIL midrst_after: got %h/%b expected %h/0", if_l1.rsp_data, if_l1.rsp_id, model_sbox(d)); end
        $display("reset mid-run: post-reset rsp=%h", if_l1.rsp_data);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_known_vectors();
        test_lanes();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
